// File: rtl/onehot_fsm_pkg.sv
// onehot_fsm_pkg
//   Shared encodings for the one-hot worker-handshake FSMs.
//   STATE_W  : width of every one-hot state register
//   state_t  : state register type
//   IDLE..ERR: legal one-hot state codes; any other value is illegal
package onehot_fsm_pkg;

  localparam int unsigned STATE_W = 5;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE  = 5'b00001;
  localparam state_t START = 5'b00010;
  localparam state_t WAIT  = 5'b00100;
  localparam state_t ACK   = 5'b01000;
  localparam state_t ERR   = 5'b10000;

endpackage

// File: rtl/job_timeout_timer.sv
// job_timeout_timer
//   Watchdog counter for the WAIT phase of the job initiator.
//   Ports:
//     clk        in  clock, rising edge
//     rst        in  asynchronous active-high reset
//     i_clear    in  zero the count (asserted the cycle before WAIT is entered)
//     i_enable   in  count this cycle (asserted in every WAIT cycle)
//     o_expired  out current enabled cycle is the last one allowed
//                    (count == TIMEOUT_CYCLES-1)
module job_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);

  logic [TmrW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TmrW'(1);
    end
  end

  assign o_expired = i_enable && (r_count == TmrW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/onehot_job_initiator.sv
// onehot_job_initiator
//   Initiator side of the start/done job handshake. Accepts a tagged request,
//   pulses worker start for one cycle, waits for done, then returns a tagged
//   one-cycle response and counts successful completions.
//   Optional build macro: JOB_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYCLES)
//   that aborts the job through ERR with o_resp_err=1.
//   Ports:
//     clk, rst          clock (rising) / asynchronous active-high reset
//     i_req_valid       job request present
//     i_req_tag         job tag, captured on acceptance
//     o_req_ready       can accept a job (IDLE only)
//     o_worker_start    one-cycle start pulse to the worker
//     i_worker_done     worker completion
//     o_resp_valid      one-cycle response pulse
//     o_resp_tag        tag of the completed/aborted job (always shows r_tag)
//     o_resp_err        job aborted by timeout, valid with o_resp_valid
//     o_busy            high in every state except IDLE
//     o_spurious_done   sticky: done seen outside WAIT
//     o_job_count       successful completions, wraps modulo 2^CNT_W
module onehot_job_initiator
  import onehot_fsm_pkg::*;
#(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
`ifdef JOB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_req_ready,
  output logic             o_worker_start,
  input  logic             i_worker_done,
  output logic             o_resp_valid,
  output logic [TAG_W-1:0] o_resp_tag,
  output logic             o_resp_err,
  output logic             o_busy,
  output logic             o_spurious_done,
  output logic [CNT_W-1:0] o_job_count
);

  state_t           r_state;
  logic [TAG_W-1:0] r_tag;
  logic [CNT_W-1:0] r_job_count;
  logic             r_spurious;

  state_t w_state_next;
  logic   w_accept;
  logic   w_timeout;

`ifdef JOB_TIMEOUT_EN
  // Clearing during START guarantees a zero count on the first WAIT cycle.
  job_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state == START),
    .i_enable (r_state == WAIT),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tag       <= '0;
      r_job_count <= '0;
      r_spurious  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_tag <= i_req_tag;
      end
      if (r_state == ACK) begin
        r_job_count <= r_job_count + CNT_W'(1);
      end
      if (i_worker_done && (r_state != WAIT)) begin
        r_spurious <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = IDLE;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_state_next = START;
          w_accept     = 1'b1;
        end
      end
      START: w_state_next = WAIT;
      WAIT: begin
        // done has priority over a coincident timeout
        if (i_worker_done) begin
          w_state_next = ACK;
        end else if (w_timeout) begin
          w_state_next = ERR;
        end else begin
          w_state_next = WAIT;
        end
      end
      ACK:     w_state_next = IDLE;
      // ERR and every non-one-hot code return to IDLE
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decode the state register only; no input reaches them combinationally.
  assign o_req_ready    = (r_state == IDLE);
  assign o_worker_start = (r_state == START);
  assign o_busy         = (r_state != IDLE);
  assign o_resp_tag     = r_tag;
`ifdef JOB_TIMEOUT_EN
  assign o_resp_valid   = (r_state == ACK) || (r_state == ERR);
  assign o_resp_err     = (r_state == ERR);
`else
  assign o_resp_valid   = (r_state == ACK);
  assign o_resp_err     = 1'b0;
`endif
  assign o_spurious_done = r_spurious;
  assign o_job_count     = r_job_count;

endmodule

// File: tb/tb_onehot_job_initiator.sv
`timescale 1ns/1ps
module tb_onehot_job_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_tag;
  logic       worker_done;

  logic       req_ready, worker_start, resp_valid, resp_err, busy, spurious_done;
  logic [3:0] resp_tag;
  logic [7:0] job_count;

  logic       req_ready2, worker_start2, resp_valid2, resp_err2, busy2, spurious_done2;
  logic [3:0] resp_tag2;
  logic [1:0] job_count2;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  onehot_job_initiator #(
    .TAG_W(4),
    .CNT_W(8)
`ifdef JOB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .i_req_tag      (req_tag),
    .o_req_ready    (req_ready),
    .o_worker_start (worker_start),
    .i_worker_done  (worker_done),
    .o_resp_valid   (resp_valid),
    .o_resp_tag     (resp_tag),
    .o_resp_err     (resp_err),
    .o_busy         (busy),
    .o_spurious_done(spurious_done),
    .o_job_count    (job_count)
  );

  // Narrow counter instance driven by the same stimulus, for wrap checks.
  onehot_job_initiator #(
    .TAG_W(4),
    .CNT_W(2)
`ifdef JOB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) u_dut2 (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .i_req_tag      (req_tag),
    .o_req_ready    (req_ready2),
    .o_worker_start (worker_start2),
    .i_worker_done  (worker_done),
    .o_resp_valid   (resp_valid2),
    .o_resp_tag     (resp_tag2),
    .o_resp_err     (resp_err2),
    .o_busy         (busy2),
    .o_spurious_done(spurious_done2),
    .o_job_count    (job_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job whose worker raises done in WAIT cycle d (start at t, resp at t+d+1).
  task automatic job(input logic [3:0] tag, input int d, input bit keep);
    req_valid = 1'b1;
    req_tag   = tag;
    tick();
    if (!keep) req_valid = 1'b0;
    req_tag = ~tag;
    chk("start_pulse", worker_start, 1);
    chk("ready_low_start", req_ready, 0);
    chk("busy_start", busy, 1);
    for (int i = 1; i <= d; i++) begin
      tick();
      chk("start_once", worker_start, 0);
      chk("no_resp_wait", resp_valid, 0);
      chk("ready_low_wait", req_ready, 0);
      if (i == d) worker_done = 1'b1;
    end
    tick();
    worker_done = 1'b0;
    chk("resp_valid", resp_valid, 1);
    chk("resp_tag", resp_tag, tag);
    chk("resp_err", resp_err, 0);
    chk("busy_ack", busy, 1);
    exp_cnt++;
    tick();
    chk("resp_one_cycle", resp_valid, 0);
    chk("ready_idle", req_ready, 1);
    chk("count8", job_count, exp_cnt & 8'hff);
    chk("count2", job_count2, exp_cnt & 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_tag     = 4'h0;
    worker_done = 1'b0;
    tick();
    tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_start", worker_start, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spurious", spurious_done, 0);
    chk("rst_count", job_count, 0);
    chk("rst_count2", job_count2, 0);
    rst = 1'b0;
    tick();

    // 1: reset pulse in the middle of WAIT drops the job
    req_valid = 1'b1;
    req_tag   = 4'h5;
    tick();
    req_valid = 1'b0;
    chk("t1_start", worker_start, 1);
    tick();
    tick();
    chk("t1_in_wait", busy, 1);
    rst = 1'b1;
    #1;
    chk("t1_async_ready", req_ready, 1);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_tag", resp_tag, 0);
    tick();
    rst = 1'b0;
    chk("t1_ready", req_ready, 1);
    chk("t1_no_resp", resp_valid, 0);
    chk("t1_count", job_count, 0);
    tick();
    chk("t1_no_resp_after", resp_valid, 0);

    // 2: single job, 3-cycle worker
    job(4'hA, 3, 1'b0);

    // 3: req_valid held high, three back-to-back jobs
    job(4'h1, 2, 1'b1);
    job(4'h2, 1, 1'b1);
    job(4'h3, 4, 1'b1);
    req_valid = 1'b0;
    chk("t3_count", job_count, 4);
    chk("spurious_still_clear", spurious_done, 0);

    // done on the last permitted WAIT cycle completes normally
    job(4'hC, 16, 1'b0);

    // 4: worker never responds
    req_valid = 1'b1;
    req_tag   = 4'h7;
    tick();
    req_valid = 1'b0;
    req_tag   = 4'h0;
`ifdef JOB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t4_no_resp_wait", resp_valid, 0);
    end
    tick();
    chk("t4_err_valid", resp_valid, 1);
    chk("t4_err_flag", resp_err, 1);
    chk("t4_err_tag", resp_tag, 4'h7);
    tick();
    chk("t4_resp_one_cycle", resp_valid, 0);
    chk("t4_err_clear", resp_err, 0);
    chk("t4_ready", req_ready, 1);
    chk("t4_count", job_count, exp_cnt);
`else
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("t4_no_resp_wait", resp_valid, 0);
    end
    chk("t4_still_busy", busy, 1);
    chk("t4_err_tied", resp_err, 0);
    rst = 1'b1;
    #1;
    chk("t4_rst_ready", req_ready, 1);
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("t4_rst_count", job_count, 0);
`endif

    // 5: spurious done in IDLE
    worker_done = 1'b1;
    tick();
    worker_done = 1'b0;
    chk("t5_spurious", spurious_done, 1);
    chk("t5_ready", req_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_start", worker_start, 0);
    tick();
    chk("t5_sticky", spurious_done, 1);
    chk("t5_no_resp", resp_valid, 0);
    job(4'h9, 3, 1'b0);
    chk("t5_sticky_after", spurious_done, 1);

    // 6: narrow counter wraps 1,2,3,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("t6_spurious_cleared", spurious_done, 0);
    chk("t6_count_zero", job_count2, 0);
    for (int k = 0; k < 5; k++) begin
      job(4'(k + 4), 2, 1'b0);
    end
    chk("t6_final2", job_count2, 1);
    chk("t6_final8", job_count, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
